// File: rtl/alu_issue.sv
// alu_issue: decode/issue stage feeding the execute ALU.
// One decode register (D) holds the incoming instruction. Its operands are read
// with writeback forwarding, and it is checked against a pending-write
// scoreboard. It then issues into a registered ALU request stage (E).
module alu_issue #(
    parameter int REG_FILE_WIDTH = 32,
    parameter int NUM_REGS       = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic [31:0]               in_instr,
    output logic                      in_ready,
    output logic [4:0]                rf_ra_addr,
    output logic [4:0]                rf_rb_addr,
    input  logic [REG_FILE_WIDTH-1:0] rf_ra_data,
    input  logic [REG_FILE_WIDTH-1:0] rf_rb_data,
    input  logic                      wb_valid,
    input  logic [4:0]                wb_addr,
    input  logic [REG_FILE_WIDTH-1:0] wb_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [5:0]                alu_op,
    output logic [REG_FILE_WIDTH-1:0] alu_x,
    output logic [REG_FILE_WIDTH-1:0] alu_y,
    output logic [4:0]                alu_rd,
    output logic                      alu_wen,
    output logic                      illegal,
    output logic [NUM_REGS-1:0]       sb_busy
);
    localparam int W = REG_FILE_WIDTH;

    localparam logic [5:0] OP_SRL = 6'h07;
    localparam logic [5:0] OP_LT  = 6'h09;
    localparam logic [5:0] OP_EQ  = 6'h0B;
    localparam logic [5:0] OP_MV  = 6'h0C;

    // decode register
    logic        d_valid;
    logic [31:0] d_instr;

    // decoded fields
    logic [5:0]  d_op;
    logic [4:0]  d_rd, d_ra, d_rb;
    logic        d_i;
    logic [9:0]  d_imm;
    logic        d_legal, d_cmp, d_mv, d_wen;
    logic        hazard, e_free, d_fire, d_drop;
    logic [W-1:0] src_a, src_b, d_y;
    logic [NUM_REGS-1:0] sb_clr, sb_set, busy_eff;

    assign d_op  = d_instr[31:26];
    assign d_rd  = d_instr[25:21];
    assign d_ra  = d_instr[20:16];
    assign d_rb  = d_instr[15:11];
    assign d_i   = d_instr[10];
    assign d_imm = d_instr[9:0];

    // 0x08 is a hole in the opcode map; everything above MV is unsupported
    assign d_legal = (d_op <= OP_SRL) || ((d_op >= OP_LT) && (d_op <= OP_MV));
    assign d_cmp   = (d_op >= OP_LT) && (d_op <= OP_EQ);
    assign d_mv    = (d_op == OP_MV);
    assign d_wen   = !d_cmp;

    assign rf_ra_addr = d_ra;
    assign rf_rb_addr = d_rb;

    // a writeback landing this cycle both forwards its data and releases the hazard
    assign src_a = (wb_valid && wb_addr == d_ra) ? wb_data : rf_ra_data;
    assign src_b = (wb_valid && wb_addr == d_rb) ? wb_data : rf_rb_data;
    assign d_y   = d_mv ? '0 :
                   d_i  ? {{(W-10){d_imm[9]}}, d_imm} : src_b;

    assign busy_eff = sb_busy & ~sb_clr;
    assign hazard   = busy_eff[d_ra]
                    || (!d_i && !d_mv && busy_eff[d_rb])
                    || (d_wen && busy_eff[d_rd]);

    assign e_free   = !out_valid || out_ready;
    assign d_fire   = d_valid && d_legal && !hazard && e_free;
    assign d_drop   = d_valid && !d_legal;
    assign in_ready = !d_valid || d_fire;
    // high exactly for the one cycle an unsupported instruction sits in D
    assign illegal  = d_drop;

    // decode register: capture on handshake, empty on issue or drop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_valid <= 1'b0;
            d_instr <= '0;
        end else if (in_valid && in_ready) begin
            d_valid <= 1'b1;
            d_instr <= in_instr;
        end else if (d_fire || d_drop) begin
            d_valid <= 1'b0;
        end
    end

    // ALU request register: load on issue, hold under backpressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            alu_op    <= '0;
            alu_x     <= '0;
            alu_y     <= '0;
            alu_rd    <= '0;
            alu_wen   <= 1'b0;
        end else if (d_fire) begin
            out_valid <= 1'b1;
            alu_op    <= d_op;
            alu_x     <= src_a;
            alu_y     <= d_y;
            alu_rd    <= d_rd;
            alu_wen   <= d_wen;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // scoreboard, one bit per register; a same-cycle issue beats a writeback
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_sb
        assign sb_clr[g] = wb_valid && (wb_addr == 5'(g));
        assign sb_set[g] = d_fire && d_wen && (d_rd == 5'(g));

        // pending-write bit for register g
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)         sb_busy[g] <= 1'b0;
            else if (sb_set[g]) sb_busy[g] <= 1'b1;
            else if (sb_clr[g]) sb_busy[g] <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: stimulus pushes expected ALU requests into a
// queue, and a monitor pops and compares each accepted request.
module tb_alu_issue;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        in_ready;
    logic [4:0]  rf_ra_addr, rf_rb_addr;
    logic [31:0] rf_ra_data, rf_rb_data;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  alu_op;
    logic [31:0] alu_x, alu_y;
    logic [4:0]  alu_rd;
    logic        alu_wen;
    logic        illegal;
    logic [31:0] sb_busy;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] x;
        logic [31:0] y;
        logic [4:0]  rd;
        logic        wen;
    } exp_t;

    exp_t        q[$];
    logic [31:0] regs[32];
    int          passed = 0;
    int          total  = 0;

    alu_issue dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
        .rf_ra_addr(rf_ra_addr), .rf_rb_addr(rf_rb_addr),
        .rf_ra_data(rf_ra_data), .rf_rb_data(rf_rb_data),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_op(alu_op), .alu_x(alu_x), .alu_y(alu_y), .alu_rd(alu_rd),
        .alu_wen(alu_wen), .illegal(illegal), .sb_busy(sb_busy)
    );

    always #5 clk = ~clk;

    assign rf_ra_data = regs[rf_ra_addr];
    assign rf_rb_data = regs[rf_rb_addr];

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd,
                                       input logic [4:0] ra, input logic [4:0] rb,
                                       input logic i, input logic [9:0] imm);
        return {op, rd, ra, rb, i, imm};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else passed++;
    endtask

    task automatic expect_req(input logic [5:0] op, input logic [31:0] x, input logic [31:0] y,
                              input logic [4:0] rd, input logic wen);
        exp_t e;
        e.op = op; e.x = x; e.y = y; e.rd = rd; e.wen = wen;
        q.push_back(e);
    endtask

    // monitor: every accepted ALU request must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            total++;
            if (q.size() == 0) begin
                $display("FAIL alu_req: unexpected op=%h x=%h y=%h rd=%0d", alu_op, alu_x, alu_y, alu_rd);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (alu_op !== e.op || alu_x !== e.x || alu_y !== e.y ||
                    alu_rd !== e.rd || alu_wen !== e.wen)
                    $display("FAIL alu_req: got op=%h x=%h y=%h rd=%0d wen=%b expected op=%h x=%h y=%h rd=%0d wen=%b",
                             alu_op, alu_x, alu_y, alu_rd, alu_wen, e.op, e.x, e.y, e.rd, e.wen);
                else passed++;
            end
        end
    end

    // all drivers below are called just after a rising edge and return there
    task automatic step;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic send(input logic [31:0] ins);
        logic got;
        logic done;
        done = 1'b0;
        in_valid = 1'b1;
        in_instr = ins;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            got = in_ready;
            step();
            if (got) done = 1'b1;
        end
        in_valid = 1'b0;
        if (!done) begin
            total++;
            $display("FAIL send_timeout: in_ready never seen for instr %h", ins);
        end
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        wb_valid = 1'b1; wb_addr = a; wb_data = d;
        step();
        regs[a]  = d;
        wb_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int r = 0; r < 32; r++) regs[r] = 32'h1000 + r;
        regs[1] = 32'h11; regs[2] = 5; regs[3] = 7; regs[5] = 9; regs[6] = 4; regs[9] = 32'h99;
        rst_n = 1'b0; in_valid = 1'b0; in_instr = '0;
        wb_valid = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b1;

        // reset state
        #2;
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_sb_busy", sb_busy, 0);
        chk("rst_illegal", 32'(illegal), 0);
        chk("rst_alu_op", 32'(alu_op), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        // back-to-back independent ops
        expect_req(6'h00, 5, 7, 5'd1, 1'b1);
        send(mk(6'h00, 5'd1, 5'd2, 5'd3, 1'b0, 10'd0));
        expect_req(6'h01, 9, 4, 5'd4, 1'b1);
        send(mk(6'h01, 5'd4, 5'd5, 5'd6, 1'b0, 10'd0));
        @(negedge clk);
        chk("b2b_first_valid", 32'(out_valid), 1);
        chk("b2b_first_rd", 32'(alu_rd), 1);
        chk("b2b_in_ready1", 32'(in_ready), 1);
        step();
        @(negedge clk);
        chk("b2b_second_valid", 32'(out_valid), 1);
        chk("b2b_second_op", 32'(alu_op), 1);
        chk("b2b_sb_busy", sb_busy, 32'h12);
        chk("b2b_in_ready2", 32'(in_ready), 1);
        step();
        wb(5'd4, 32'h44);

        // RAW stall on r1, released by a forwarded writeback
        expect_req(6'h03, 32'h1234, 5, 5'd7, 1'b1);
        send(mk(6'h03, 5'd7, 5'd1, 5'd2, 1'b0, 10'd0));
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("raw_stall_in_ready", 32'(in_ready), 0);
            chk("raw_stall_out_valid", 32'(out_valid), 0);
            step();
        end
        wb_valid = 1'b1; wb_addr = 5'd1; wb_data = 32'h1234;
        @(negedge clk);
        chk("raw_fire_in_ready", 32'(in_ready), 1);
        step();
        regs[1] = 32'h1234; wb_valid = 1'b0;
        @(negedge clk);
        chk("raw_issue_valid", 32'(out_valid), 1);
        chk("raw_sb_busy", sb_busy, 32'h80);
        step();
        wb(5'd7, 32'h77);
        @(negedge clk);
        chk("raw_sb_clear", sb_busy, 0);
        step();

        // sign-extended immediate
        expect_req(6'h00, 7, 32'hFFFF_FFFF, 5'd2, 1'b1);
        send(mk(6'h00, 5'd2, 5'd3, 5'd0, 1'b1, 10'h3FF));
        idle(2);
        wb(5'd2, 32'h22);

        // compare op does not write a register
        expect_req(6'h0B, 32'h99, 7, 5'd10, 1'b0);
        send(mk(6'h0B, 5'd10, 5'd9, 5'd3, 1'b0, 10'd0));
        step();
        @(negedge clk);
        chk("cmp_wen", 32'(alu_wen), 0);
        chk("cmp_sb_busy", sb_busy, 0);
        step();
        idle(1);

        // backpressure holds E and stalls D
        out_ready = 1'b0;
        expect_req(6'h00, 9, 4, 5'd11, 1'b1);
        send(mk(6'h00, 5'd11, 5'd5, 5'd6, 1'b0, 10'd0));
        expect_req(6'h01, 7, 9, 5'd12, 1'b1);
        send(mk(6'h01, 5'd12, 5'd3, 5'd5, 1'b0, 10'd0));
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("bp_hold_x", alu_x, 9);
            chk("bp_hold_valid", 32'(out_valid), 1);
            chk("bp_in_ready", 32'(in_ready), 0);
            step();
        end
        out_ready = 1'b1;
        idle(2);
        @(negedge clk);
        chk("bp_drained", 32'(out_valid), 0);
        step();
        wb(5'd11, 32'hB);
        wb(5'd12, 32'hC);

        // unsupported opcodes are dropped with a one-cycle pulse
        send(mk(6'h08, 5'd1, 5'd2, 5'd3, 1'b0, 10'd0));
        @(negedge clk);
        chk("ill08_pulse", 32'(illegal), 1);
        chk("ill08_no_issue", 32'(out_valid), 0);
        step();
        @(negedge clk);
        chk("ill08_pulse_end", 32'(illegal), 0);
        chk("ill08_no_issue2", 32'(out_valid), 0);
        chk("ill08_sb", sb_busy, 0);
        step();
        send(mk(6'h3F, 5'd1, 5'd2, 5'd3, 1'b0, 10'd0));
        @(negedge clk);
        chk("ill3f_pulse", 32'(illegal), 1);
        step();

        // asynchronous reset in the middle of a stall discards both stages
        out_ready = 1'b0;
        send(mk(6'h00, 5'd13, 5'd2, 5'd3, 1'b0, 10'd0));
        send(mk(6'h03, 5'd14, 5'd13, 5'd3, 1'b0, 10'd0));
        @(negedge clk);
        chk("pre_rst_valid", 32'(out_valid), 1);
        chk("pre_rst_sb", sb_busy, 32'h2000);
        chk("pre_rst_in_ready", 32'(in_ready), 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 0);
        chk("arst_sb", sb_busy, 0);
        chk("arst_in_ready", 32'(in_ready), 1);
        chk("arst_alu_x", alu_x, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        idle(3);
        @(negedge clk);
        chk("post_rst_valid", 32'(out_valid), 0);
        chk("post_rst_in_ready", 32'(in_ready), 1);
        chk("queue_empty", 32'(q.size()), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
